psg_array: RTL and testbench

- Parametrised multi-AY sound block, successor to the two-chip TurboSound pair.
- Instantiates 1..4 jt49_bus PSGs behind a single AY bus. A select/pan command chooses which chip receives register traffic and reads.
- Each chip has left/right enables. A registered stereo mixer produces summed L/R samples for the audio DAC/sigma-delta stage.

---
 rtl/psg_array_pkg.sv | 15 +
 rtl/jt49_bus.sv | 39 +++
 rtl/psg_mixer.sv | 80 ++++++++
 rtl/psg_array.sv | 96 +++++++++
 tb/tb_psg_array.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/psg_array_pkg.sv
// rtl/psg_array_pkg.sv - shared constants for the multi-PSG sound block
package psg_array_pkg;

    localparam int STEREO_ABC  = 0;
    localparam int STEREO_ACB  = 1;
    localparam int STEREO_MONO = 2;

    localparam int       CMD_BIT  = 7;
    localparam logic [2:0] CMD_TAG = 3'b111;
    localparam int       EN_L_BIT = 6;
    localparam int       EN_R_BIT = 5;

    localparam int MIX_W = 11;

endpackage

// File: rtl/jt49_bus.sv
// rtl/jt49_bus.sv - AY-compatible register file and channel level outputs
// Compact stand-in: channel levels follow the 4-bit amplitude registers directly.
module jt49_bus (
    input  logic       rst_n,
    input  logic       clk,
    input  logic       clk_en,
    input  logic       bdir,
    input  logic       bc1,
    input  logic [7:0] din,
    input  logic       sel,
    output logic [7:0] dout,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [7:0] c
);

    logic [7:0] regs [16];
    logic [3:0] addr;
    logic       unused_ok;

    assign unused_ok = ^{clk_en, sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (bdir && bc1) begin
            addr <= din[3:0];
        end else if (bdir && !bc1) begin
            regs[addr] <= din;
        end
    end

    assign dout = regs[addr];
    assign a    = {regs[8][3:0],  regs[8][3:0]};
    assign b    = {regs[9][3:0],  regs[9][3:0]};
    assign c    = {regs[10][3:0], regs[10][3:0]};

endmodule

// File: rtl/psg_mixer.sv
// rtl/psg_mixer.sv - two-stage ce-paced stereo mixer over CHIPS PSGs
module psg_mixer
    import psg_array_pkg::*;
#(
    parameter int CHIPS  = 2,
    parameter int STEREO = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic [8*CHIPS-1:0]   a,
    input  logic [8*CHIPS-1:0]   b,
    input  logic [8*CHIPS-1:0]   c,
    input  logic [CHIPS-1:0]     en_l,
    input  logic [CHIPS-1:0]     en_r,
    output logic [MIX_W-1:0]     left,
    output logic [MIX_W-1:0]     right
);

    logic [9:0]       mono3 [CHIPS];
    logic [8:0]       nl    [CHIPS];
    logic [8:0]       nr    [CHIPS];
    logic [8:0]       l1    [CHIPS];
    logic [8:0]       r1    [CHIPS];
    logic [MIX_W-1:0] sum_l;
    logic [MIX_W-1:0] sum_r;

    always_comb begin
        for (int i = 0; i < CHIPS; i++) begin
            mono3[i] = 10'(a[8*i +: 8]) + 10'(b[8*i +: 8]) + 10'(c[8*i +: 8]);
            if (STEREO == STEREO_MONO) begin
                nl[i] = mono3[i][9:1];
                nr[i] = mono3[i][9:1];
            end else if (STEREO == STEREO_ACB) begin
                nl[i] = 9'(a[8*i +: 8]) + 9'(c[8*i+1 +: 7]);
                nr[i] = 9'(b[8*i +: 8]) + 9'(c[8*i+1 +: 7]);
            end else begin
                nl[i] = 9'(a[8*i +: 8]) + 9'(b[8*i+1 +: 7]);
                nr[i] = 9'(c[8*i +: 8]) + 9'(b[8*i+1 +: 7]);
            end
            if (!en_l[i]) nl[i] = '0;
            if (!en_r[i]) nr[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHIPS; i++) begin
                l1[i] <= '0;
                r1[i] <= '0;
            end
        end else if (ce) begin
            for (int i = 0; i < CHIPS; i++) begin
                l1[i] <= nl[i];
                r1[i] <= nr[i];
            end
        end
    end

    // 4 x 382 fits in MIX_W bits, so the sum never wraps
    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < CHIPS; i++) begin
            sum_l = sum_l + MIX_W'(l1[i]);
            sum_r = sum_r + MIX_W'(r1[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left  <= '0;
            right <= '0;
        end else if (ce) begin
            left  <= sum_l;
            right <= sum_r;
        end
    end

endmodule

// File: rtl/psg_array.sv
// rtl/psg_array.sv - 1..4 PSGs behind one AY bus with select/pan command and stereo mix
module psg_array
    import psg_array_pkg::*;
#(
    parameter int CHIPS  = 2,
    parameter int STEREO = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 bdir,
    input  logic                 bc1,
    input  logic [7:0]           d,
    output logic [7:0]           q,
    output logic [8*CHIPS-1:0]   a,
    output logic [8*CHIPS-1:0]   b,
    output logic [8*CHIPS-1:0]   c,
    output logic [MIX_W-1:0]     left,
    output logic [MIX_W-1:0]     right
);

    logic             cmd;
    logic [1:0]       idx;
    logic             valid;
    logic [1:0]       sel;
    logic [CHIPS-1:0] en_l;
    logic [CHIPS-1:0] en_r;
    logic [7:0]       dout [CHIPS];

    assign cmd   = bdir & bc1 & d[CMD_BIT] & (d[4:2] == CMD_TAG);
    assign idx   = ~d[1:0];
    assign valid = cmd && (32'(idx) < CHIPS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel  <= '0;
            en_l <= '1;
            en_r <= '1;
        end else if (valid) begin
            sel <= idx;
            for (int i = 0; i < CHIPS; i++) begin
                if (idx == 2'(i)) begin
                    en_l[i] <= d[EN_L_BIT];
                    en_r[i] <= d[EN_R_BIT];
                end
            end
        end
    end

    // routing looks at the pre-update sel; command cycles never reach a chip
    for (genvar i = 0; i < CHIPS; i++) begin : g_chip
        logic chip_bdir;
        logic chip_bc1;

        assign chip_bdir = (sel == 2'(i)) & ~cmd & bdir;
        assign chip_bc1  = (sel == 2'(i)) & ~cmd & bc1;

        jt49_bus u_psg (
            .rst_n  (reset),
            .clk    (clock),
            .clk_en (ce),
            .bdir   (chip_bdir),
            .bc1    (chip_bc1),
            .din    (d),
            .sel    (1'b0),
            .dout   (dout[i]),
            .a      (a[8*i +: 8]),
            .b      (b[8*i +: 8]),
            .c      (c[8*i +: 8])
        );
    end

    always_comb begin
        q = '0;
        for (int i = 0; i < CHIPS; i++) begin
            if (sel == 2'(i)) q = dout[i];
        end
    end

    psg_mixer #(
        .CHIPS  (CHIPS),
        .STEREO (STEREO)
    ) u_mixer (
        .clk   (clock),
        .rst_n (reset),
        .ce    (ce),
        .a     (a),
        .b     (b),
        .c     (c),
        .en_l  (en_l),
        .en_r  (en_r),
        .left  (left),
        .right (right)
    );

endmodule

// File: tb/tb_psg_array.sv
// tb/tb_psg_array.sv - directed bench for psg_array (2-chip ABC and 4-chip mono)
module tb_psg_array;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reset4 = 1'b0;
    logic        ce = 1'b0;
    logic        bdir = 1'b0;
    logic        bc1 = 1'b0;
    logic [7:0]  d = 8'h00;

    logic [7:0]  q2, q4;
    logic [15:0] a2, b2, c2;
    logic [31:0] a4, b4, c4;
    logic [10:0] left2, right2, left4, right4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    psg_array #(.CHIPS(2), .STEREO(0)) dut2 (
        .clock (clock), .reset (reset), .ce (ce),
        .bdir (bdir), .bc1 (bc1), .d (d), .q (q2),
        .a (a2), .b (b2), .c (c2), .left (left2), .right (right2)
    );

    psg_array #(.CHIPS(4), .STEREO(2)) dut4 (
        .clock (clock), .reset (reset4), .ce (ce),
        .bdir (bdir), .bc1 (bc1), .d (d), .q (q4),
        .a (a4), .b (b4), .c (c4), .left (left4), .right (right4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic bd, input logic b1, input logic [7:0] val);
        @(negedge clock);
        bdir = bd;
        bc1  = b1;
        d    = val;
        @(posedge clock);
        #1;
        bdir = 1'b0;
        bc1  = 1'b0;
        d    = 8'h00;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] val);
        bus(1'b1, 1'b1, addr);
        bus(1'b1, 1'b0, val);
    endtask

    task automatic ce_tick();
        @(negedge clock);
        ce = 1'b1;
        @(posedge clock);
        #1;
        ce = 1'b0;
    endtask

    task automatic rd_setup();
        @(negedge clock);
        bdir = 1'b0;
        bc1  = 1'b1;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("reset_left", left2, 0);
        check("reset_right", right2, 0);
        check("reset_q", q2, 0);
        @(negedge clock);
        reset  = 1'b1;
        reset4 = 1'b1;

        // chip0 programming and readback
        wr_reg(8'h07, 8'h38);
        wr_reg(8'h08, 8'h0F);
        rd_setup();
        check("t1_q_reg8", q2, 8'h0F);
        bc1 = 1'b0;
        check("t1_chip0_a", a2[7:0], 8'hFF);
        check("t1_chip1_a", a2[15:8], 8'h00);

        // select chip1, write its amplitude, then back to chip0
        bus(1'b1, 1'b1, 8'hFE);
        wr_reg(8'h08, 8'h0A);
        check("t2_chip1_a", a2[15:8], 8'hAA);
        check("t2_chip0_a", a2[7:0], 8'hFF);
        rd_setup();
        check("t2_q_chip1", q2, 8'h0A);
        bc1 = 1'b0;
        bus(1'b1, 1'b1, 8'hFF);
        rd_setup();
        check("t2_q_chip0_latch", q2, 8'h0F);
        bc1 = 1'b0;

        // idx 2 is out of range for two chips: no select, no latch
        bus(1'b1, 1'b1, 8'hFD);
        rd_setup();
        check("t3_q_unchanged", q2, 8'h0F);
        bc1 = 1'b0;
        wr_reg(8'h09, 8'h04);
        check("t3_chip0_b", b2[7:0], 8'h44);
        check("t3_chip1_b", b2[15:8], 8'h00);

        // both chips A=0x88, B=0x44, C=0
        wr_reg(8'h08, 8'h08);
        bus(1'b1, 1'b1, 8'hFE);
        wr_reg(8'h08, 8'h08);
        wr_reg(8'h09, 8'h04);
        repeat (3) @(posedge clock);
        #1;
        check("t4_frozen_left", left2, 0);
        ce_tick();
        check("t4_tick1_left", left2, 0);
        ce_tick();
        check("t4_tick2_left", left2, 340);
        check("t4_tick2_right", right2, 68);

        // chip0 left off
        bus(1'b1, 1'b1, 8'hBF);
        repeat (4) @(posedge clock);
        #1;
        check("t5_frozen_left", left2, 340);
        ce_tick();
        check("t5_tick1_left", left2, 340);
        ce_tick();
        check("t5_tick2_left", left2, 170);
        check("t5_tick2_right", right2, 68);

        // four-chip mono, every channel full scale
        for (int k = 0; k < 4; k++) begin
            bus(1'b1, 1'b1, 8'hFC | 8'(3 - k));
            wr_reg(8'h08, 8'h0F);
            wr_reg(8'h09, 8'h0F);
            wr_reg(8'h0A, 8'h0F);
        end
        ce_tick();
        ce_tick();
        check("t6_mono_left", left4, 1528);
        check("t6_mono_right", right4, 1528);

        @(negedge clock);
        ce = 1'b1;
        @(posedge clock);
        #3;
        reset4 = 1'b0;
        #1;
        check("t6_async_left", left4, 0);
        check("t6_async_right", right4, 0);
        @(negedge clock);
        reset4 = 1'b1;
        @(posedge clock);
        #1;
        check("t6_post_release", left4, 0);
        ce = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
